// File: rtl/requant_relu.sv
// Requantizes a signed MAC result (round-half-up shift, optional ReLU, saturate) into a small output FIFO.
// Latency: two register stages, so an accepted result is visible at the FIFO head two edges later.
// Backpressure: mac_ready_o drops once buffered plus in-flight results would fill the FIFO.
module requant_relu #(
    parameter int ACC_BIT_RESOLUTION = 32,
    parameter int OUT_BIT_RESOLUTION = 8,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          mac_valid_i,
    input  logic [ACC_BIT_RESOLUTION-1:0] mac_data_i,
    output logic                          mac_ready_o,
    input  logic [4:0]                    shift_i,
    input  logic                          relu_en_i,
    output logic                          out_valid_o,
    output logic [OUT_BIT_RESOLUTION-1:0] out_data_o,
    output logic                          out_sat_o,
    input  logic                          out_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int AW = ACC_BIT_RESOLUTION;
    localparam int OW = OUT_BIT_RESOLUTION;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Output range expressed at the widened accumulator width for signed compares.
    localparam logic signed [AW:0] OUT_MAX = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0] OUT_MIN = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    typedef struct packed {
        logic          sat;
        logic [OW-1:0] dat;
    } entry_t;

    logic               accept;
    logic signed [AW:0] x_ext;
    logic signed [AW:0] rnd;
    logic signed [AW:0] r1_nxt;

    logic               s1_vld;
    logic               s1_relu;
    logic signed [AW:0] s1_r;

    logic signed [AW:0] r2;
    entry_t             s2_nxt;
    logic               s2_vld;
    entry_t             s2_ent;

    entry_t             mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      fifo_cnt;
    logic               rd_fire;
    logic [CW:0]        occ;
    entry_t             rd_ent;

    // One extra bit of headroom keeps the rounding add from wrapping at full scale.
    always_comb begin
        x_ext = $signed({mac_data_i[AW-1], mac_data_i});
        rnd   = '0;
        if (shift_i != 5'd0) begin
            rnd = (AW+1)'(1) << (shift_i - 5'd1);
        end
        r1_nxt = (x_ext + rnd) >>> shift_i;
    end

    always_comb begin
        r2          = (s1_relu && s1_r[AW]) ? '0 : s1_r;
        s2_nxt.sat  = 1'b0;
        s2_nxt.dat  = r2[OW-1:0];
        if (r2 > OUT_MAX) begin
            s2_nxt.sat = 1'b1;
            s2_nxt.dat = OUT_MAX[OW-1:0];
        end else if (r2 < OUT_MIN) begin
            s2_nxt.sat = 1'b1;
            s2_nxt.dat = OUT_MIN[OW-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= accept;
            s2_vld <= s1_vld;
        end
    end

    // Shift and ReLU enable are captured with the data so later changes cannot leak in.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            s1_r    <= r1_nxt;
            s1_relu <= relu_en_i;
        end
        if (s1_vld) begin
            s2_ent <= s2_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (s2_vld) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({s2_vld, rd_fire})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (s2_vld) begin
            mem[wr_ptr] <= s2_ent;
        end
    end

    // Space is reserved for everything still in the pipeline, so writes never find the FIFO full.
    assign occ          = (CW+1)'(fifo_cnt) + (CW+1)'(s1_vld) + (CW+1)'(s2_vld);
    assign mac_ready_o  = rst_ni && (occ < (CW+1)'(FIFO_DEPTH));
    assign accept       = mac_valid_i && mac_ready_o;

    assign out_valid_o  = (fifo_cnt != '0);
    assign rd_fire      = out_valid_o && out_ready_i;
    assign rd_ent       = out_valid_o ? mem[rd_ptr] : '0;
    assign out_data_o   = rd_ent.dat;
    assign out_sat_o    = rd_ent.sat;
    assign fifo_count_o = fifo_cnt;

endmodule

// File: tb/tb_requant_relu.sv
// Bench for requant_relu: queue-based cycle model plus directed vectors with hand-computed results.
module tb_requant_relu;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mac_valid;
    logic [31:0] mac_data;
    logic        mac_ready;
    logic [4:0]  shift;
    logic        relu_en;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sat;
    logic        out_ready;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    requant_relu #(
        .ACC_BIT_RESOLUTION(32),
        .OUT_BIT_RESOLUTION(8),
        .FIFO_DEPTH(D)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .mac_valid_i(mac_valid),
        .mac_data_i(mac_data),
        .mac_ready_o(mac_ready),
        .shift_i(shift),
        .relu_en_i(relu_en),
        .out_valid_o(out_valid),
        .out_data_o(out_data),
        .out_sat_o(out_sat),
        .out_ready_i(out_ready),
        .fifo_count_o(fifo_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {sat, data} computed with plain integer arithmetic.
    function automatic logic [8:0] model_fn(input logic [31:0] x, input logic [4:0] sh, input logic relu);
        longint v;
        logic   sat;
        v = longint'($signed(x));
        if (sh != 5'd0) v = v + (longint'(1) <<< (sh - 5'd1));
        v = v >>> sh;
        sat = 1'b0;
        if (relu && v < 0) v = 0;
        if (v > 127) begin
            v = 127;
            sat = 1'b1;
        end else if (v < -128) begin
            v = -128;
            sat = 1'b1;
        end
        return {sat, v[7:0]};
    endfunction

    // Cycle model: accepted words become visible two edges later; buffered words leave on a handshake.
    logic [8:0] buf_q[$];
    logic [8:0] infl_v[$];
    int         infl_due[$];
    int         edge_n = 0;
    bit         armed  = 1'b0;

    always @(posedge clk) begin : model
        bit rdy;
        edge_n++;
        if (!rst_n) begin
            buf_q.delete();
            infl_v.delete();
            infl_due.delete();
            armed = 1'b1;
        end else begin
            rdy = (buf_q.size() + infl_v.size()) < D;
            if (buf_q.size() > 0 && out_ready) void'(buf_q.pop_front());
            while (infl_v.size() > 0 && infl_due[0] == edge_n) begin
                buf_q.push_back(infl_v.pop_front());
                void'(infl_due.pop_front());
            end
            if (mac_valid && rdy) begin
                infl_v.push_back(model_fn(mac_data, shift, relu_en));
                infl_due.push_back(edge_n + 2);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("mac_ready", 32'(mac_ready), 32'(rst_n && ((buf_q.size() + infl_v.size()) < D)));
            chk("out_valid", 32'(out_valid), 32'(buf_q.size() > 0));
            chk("fifo_count", 32'(fifo_count), 32'(buf_q.size()));
            if (buf_q.size() > 0) chk("out_word", 32'({out_sat, out_data}), 32'(buf_q[0]));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_dir(input logic [31:0] x, input logic [4:0] sh, input logic rl, input logic [8:0] exp);
        bit acc;
        int n;
        chk("model_pin", 32'(model_fn(x, sh, rl)), 32'(exp));
        mac_valid = 1'b1;
        mac_data  = x;
        shift     = sh;
        relu_en   = rl;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = mac_ready;
            tick();
        end
        mac_valid = 1'b0;
        shift     = ~sh;
        relu_en   = ~rl;
        mac_data  = ~x;
        chk("dir_accepted", 32'(acc), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk("dir_latency", 32'(n), 32'd3);
        chk("dir_word", 32'({out_sat, out_data}), 32'(exp));
        tick();
    endtask

    int acc_cnt;
    int first_c, last_c, val_cnt;
    logic [8:0] hold;
    int n;

    initial begin
        rst_n     = 1'b0;
        mac_valid = 1'b0;
        mac_data  = '0;
        shift     = '0;
        relu_en   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_count", 32'(fifo_count), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", 32'(mac_ready), 32'd1);

        out_ready = 1'b1;
        send_dir(32'h00001280, 5'd8, 1'b0, 9'h013);
        send_dir(32'hFFFFFFFD, 5'd1, 1'b0, 9'h0FF);
        send_dir(32'hFFFFFF80, 5'd0, 1'b1, 9'h000);
        send_dir(32'hFFFFFF80, 5'd0, 1'b0, 9'h080);
        send_dir(32'h00010000, 5'd4, 1'b0, 9'h17F);
        send_dir(32'h80000000, 5'd0, 1'b0, 9'h180);
        send_dir(32'h7FFFFFFF, 5'd1, 1'b0, 9'h17F);
        send_dir(32'h00000180, 5'd8, 1'b0, 9'h002);
        send_dir(32'hFFFFFE80, 5'd8, 1'b0, 9'h0FF);
        send_dir(32'h00000500, 5'd4, 1'b1, 9'h050);
        send_dir(32'h80000000, 5'd0, 1'b1, 9'h000);

        // Backpressure: six back-to-back offers into a stalled output.
        out_ready = 1'b0;
        acc_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            mac_valid = 1'b1;
            mac_data  = 32'(i * 560 - 1200);
            shift     = 5'd3;
            relu_en   = 1'b0;
            acc_cnt  += int'(mac_ready);
            tick();
        end
        mac_valid = 1'b0;
        repeat (3) tick();
        chk("bp_accepted", 32'(acc_cnt), 32'd4);
        @(negedge clk);
        chk("bp_ready_low", 32'(mac_ready), 32'd0);
        chk("bp_count", 32'(fifo_count), 32'd4);
        hold = {out_sat, out_data};
        repeat (3) @(negedge clk);
        chk("bp_stable", 32'({out_sat, out_data}), 32'(hold));
        tick();
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mac_ready && n < 10);
        chk("bp_ready_rise", 32'(mac_ready), 32'd1);
        repeat (6) tick();

        // Streaming: sixteen back-to-back words with the consumer always ready.
        first_c = 0;
        last_c  = 0;
        val_cnt = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    mac_valid = 1'b1;
                    mac_data  = 32'(i) * 32'h01010101 - 32'h00800000;
                    shift     = 5'(i * 2);
                    relu_en   = i[0];
                    tick();
                end
                mac_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 24; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (first_c == 0) first_c = c;
                        last_c = c;
                        val_cnt++;
                    end
                end
            end
        join
        chk("stream_first", 32'(first_c), 32'd4);
        chk("stream_last", 32'(last_c), 32'd19);
        chk("stream_count", 32'(val_cnt), 32'd16);
        tick();

        // Reset with three buffered words.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mac_valid = 1'b1;
            mac_data  = 32'((i + 1) * 1000);
            shift     = 5'd2;
            tick();
        end
        mac_valid = 1'b0;
        repeat (4) tick();
        chk("rst_pre_count", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready_low", 32'(mac_ready), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_ready_release", 32'(mac_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(out_valid), 32'd0);
        end
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
